// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single SRAM port arbiter between IF fetch and EX data access
//
// Shares one synchronous SRAM port between instruction fetch (IF) and data
// access (EX). EX wins conflicts unless IF has been refused STARVE_MAX
// consecutive cycles, in which case IF wins one conflict. The owner of the
// outstanding read is tracked so the returning mem_rdata (one cycle after
// the address) is routed to the right requester.
//
// Optional feature macro: ARB_PERF_CNT_EN (conflict / override counters).
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               IF read request
//   if_gnt/if_rvalid/if_rdata    IF grant and read return
//   ex_req/ex_wen/ex_addr/ex_wdata  EX request (ex_wen==0 is a read)
//   ex_gnt/ex_rvalid/ex_rdata    EX grant and read return
//   mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata  shared SRAM port
//   stallreq                     a requester was refused this cycle
//   conflict_cnt/override_cnt    performance counters (0 unless enabled)

module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             ex_req,
    input  logic [3:0]       ex_wen,
    input  logic [31:0]      ex_addr,
    input  logic [31:0]      ex_wdata,
    output logic             ex_gnt,
    output logic             ex_rvalid,
    output logic [31:0]      ex_rdata,
    output logic             mem_en,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             stallreq,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [CNT_W-1:0] override_cnt
);

    // A zero-width counter is not legal; with STARVE_MAX==0 a 1-bit
    // counter that never leaves 0 is kept instead.
    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_EX   = 2'd2
    } owner_e;

    owner_e          owner_q, owner_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            force_if;

    assign force_if = (STARVE_MAX != 0) && if_req && ex_req && (starve_q == SC_MAX);
    assign if_gnt   = if_req && (!ex_req || force_if);
    assign ex_gnt   = ex_req && !if_gnt;
    assign stallreq = (if_req && !if_gnt) || (ex_req && !ex_gnt);

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (ex_gnt) begin
            mem_en    = 1'b1;
            mem_wen   = ex_wen;
            mem_addr  = ex_addr;
            mem_wdata = ex_wdata;
        end
    end

    always_comb begin
        starve_d = '0;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == SC_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    // Writes produce no return data, so they leave the port unowned.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ex_gnt && (ex_wen == 4'h0)) begin
            owner_d = OWN_EX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Return path decodes the owner register directly, so an asynchronous
    // reset kills rvalid immediately.
    assign if_rvalid = (owner_q == OWN_IF);
    assign ex_rvalid = (owner_q == OWN_EX);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign ex_rdata  = ex_rvalid ? mem_rdata : 32'h0;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] conflict_q;
    logic [CNT_W-1:0] override_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= '0;
            override_q <= '0;
        end else begin
            conflict_q <= conflict_q + CNT_W'(if_req && ex_req);
            override_q <= override_q + CNT_W'(force_if);
        end
    end

    assign conflict_cnt = conflict_q;
    assign override_cnt = override_q;
`else
    assign conflict_cnt = '0;
    assign override_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 32;
`ifdef ARB_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [31:0]      if_rdata;
    logic             ex_req;
    logic [3:0]       ex_wen;
    logic [31:0]      ex_addr;
    logic [31:0]      ex_wdata;
    logic             ex_gnt;
    logic             ex_rvalid;
    logic [31:0]      ex_rdata;
    logic             mem_en;
    logic [3:0]       mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             stallreq;
    logic [CNT_W-1:0] conflict_cnt;
    logic [CNT_W-1:0] override_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_wen(ex_wen), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq(stallreq), .conflict_cnt(conflict_cnt), .override_cnt(override_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] g, input logic [1:0] rv,
                                 input logic [31:0] ird, input logic [31:0] erd,
                                 input logic en, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic stall);
        chk({tag, ".gnt"},       {30'h0, if_gnt, ex_gnt}, {30'h0, g});
        chk({tag, ".rvalid"},    {30'h0, if_rvalid, ex_rvalid}, {30'h0, rv});
        chk({tag, ".if_rdata"},  if_rdata, ird);
        chk({tag, ".ex_rdata"},  ex_rdata, erd);
        chk({tag, ".mem_en"},    {31'h0, mem_en}, {31'h0, en});
        chk({tag, ".mem_wen"},   {28'h0, mem_wen}, {28'h0, wen});
        chk({tag, ".mem_addr"},  mem_addr, addr);
        chk({tag, ".mem_wdata"}, mem_wdata, wdata);
        chk({tag, ".stallreq"},  {31'h0, stallreq}, {31'h0, stall});
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ex_req;
        logic [3:0]  ex_wen;
        logic [31:0] ex_addr;
        logic [31:0] ex_wdata;
        logic [31:0] mem_rdata;
        logic [1:0]  e_gnt;    // {if, ex}
        logic [1:0]  e_rv;     // {if, ex}
        logic [31:0] e_rdata;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
    } vec_t;

    vec_t tbl [14];

    // reference model state
    int          m_starve;
    int          m_owner;   // 0 none, 1 IF, 2 EX
    int          m_conf;
    int          m_ovr;
    int          winner;
    logic        ovr;
    logic        if_pend;
    logic        ex_pend;
    logic [31:0] cnt_exp;

    initial begin
        // IF-only read, then EX store, then six conflict cycles with override,
        // then alternating single-requester reads.
        tbl[0]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                    2'b10, 2'b00, 32'h0, 1'b1, 4'h0, 32'hBFC00000, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h24080001,
                    2'b00, 2'b10, 32'h24080001, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'h1234ABCD, 32'h0,
                    2'b01, 2'b00, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'h1234ABCD, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                    2'b00, 2'b00, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h0,
                    2'b01, 2'b00, 32'h0, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 1'b1};
        tbl[5]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h11111111,
                    2'b01, 2'b01, 32'h11111111, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 1'b1};
        tbl[6]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h22222222,
                    2'b01, 2'b01, 32'h22222222, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 1'b1};
        tbl[7]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h33333333,
                    2'b01, 2'b01, 32'h33333333, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 1'b1};
        tbl[8]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h44444444,
                    2'b10, 2'b01, 32'h44444444, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'h100, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 32'h55555555,
                    2'b01, 2'b10, 32'h55555555, 1'b1, 4'h0, 32'h200, 32'hAAAA5555, 1'b1};
        tbl[10] = '{1'b1, 32'h300, 1'b0, 4'h0, 32'h0, 32'h0, 32'h66666666,
                    2'b10, 2'b01, 32'h66666666, 1'b1, 4'h0, 32'h300, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h400, 32'h0, 32'h77777777,
                    2'b01, 2'b10, 32'h77777777, 1'b1, 4'h0, 32'h400, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 32'h304, 1'b0, 4'h0, 32'h0, 32'h0, 32'h88888888,
                    2'b10, 2'b01, 32'h88888888, 1'b1, 4'h0, 32'h304, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h99999999,
                    2'b00, 2'b10, 32'h99999999, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};

        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ex_req = 1'b0; ex_wen = 4'h0; ex_addr = 32'h0; ex_wdata = 32'h0;
        mem_rdata = 32'hFFFFFFFF;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.if_rvalid", {31'h0, if_rvalid}, 32'h0);
        chk("rst.ex_rvalid", {31'h0, ex_rvalid}, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.ex_rdata", ex_rdata, 32'h0);
        chk("rst.conflict_cnt", conflict_cnt, 32'h0);
        chk("rst.override_cnt", override_cnt, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if_req = tbl[i].if_req;   if_addr = tbl[i].if_addr;
            ex_req = tbl[i].ex_req;   ex_wen = tbl[i].ex_wen;
            ex_addr = tbl[i].ex_addr; ex_wdata = tbl[i].ex_wdata;
            mem_rdata = tbl[i].mem_rdata;
            @(negedge clk);
            check_outputs($sformatf("tbl%0d", i), tbl[i].e_gnt, tbl[i].e_rv,
                          tbl[i].e_rv[1] ? tbl[i].e_rdata : 32'h0,
                          tbl[i].e_rv[0] ? tbl[i].e_rdata : 32'h0,
                          tbl[i].e_en, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_wdata,
                          tbl[i].e_stall);
            @(posedge clk);
            #1;
        end
        chk("tbl.conflict_cnt", conflict_cnt, (PERF != 0) ? 32'd6 : 32'd0);
        chk("tbl.override_cnt", override_cnt, (PERF != 0) ? 32'd1 : 32'd0);

        // reset asserted mid-cycle while an IF read is outstanding
        if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h0;
        @(negedge clk);
        chk("mid.if_gnt0", {31'h0, if_gnt}, 32'h1);
        @(posedge clk);
        #1;
        if_addr = 32'h504; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("mid.if_rvalid_pre", {31'h0, if_rvalid}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("mid.if_rvalid_rst", {31'h0, if_rvalid}, 32'h0);
        chk("mid.if_rdata_rst", if_rdata, 32'h0);
        chk("mid.if_gnt_rst", {31'h0, if_gnt}, 32'h1);
        chk("mid.mem_addr_rst", mem_addr, 32'h504);
        if_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid.if_rvalid_post", {31'h0, if_rvalid}, 32'h0);
        chk("mid.ex_rvalid_post", {31'h0, ex_rvalid}, 32'h0);
        chk("mid.if_rdata_post", if_rdata, 32'h0);
        chk("mid.conflict_post", conflict_cnt, 32'h0);
        chk("mid.override_post", override_cnt, 32'h0);
        @(posedge clk);
        #1;

        // randomized traffic against the reference model
        m_starve = 0; m_owner = 0; m_conf = 0; m_ovr = 0;
        if_pend = 1'b0; ex_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_pend) begin
                if_req  = ($urandom_range(0, 99) < 55);
                if_addr = $urandom;
            end
            if (!ex_pend) begin
                ex_req   = ($urandom_range(0, 99) < 65);
                ex_addr  = $urandom;
                ex_wdata = $urandom;
                ex_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end
            mem_rdata = $urandom;

            ovr = (STARVE_MAX != 0) && if_req && ex_req && (m_starve == STARVE_MAX);
            winner = 0;
            if (ex_req) winner = 2;
            if (if_req && (!ex_req || ovr)) winner = 1;

            @(negedge clk);
            check_outputs($sformatf("rnd%0d", c),
                          {winner == 1, winner == 2},
                          {m_owner == 1, m_owner == 2},
                          (m_owner == 1) ? mem_rdata : 32'h0,
                          (m_owner == 2) ? mem_rdata : 32'h0,
                          winner != 0,
                          (winner == 2) ? ex_wen : 4'h0,
                          (winner == 1) ? if_addr : (winner == 2) ? ex_addr : 32'h0,
                          (winner == 2) ? ex_wdata : 32'h0,
                          (if_req && winner != 1) || (ex_req && winner != 2));
            cnt_exp = (PERF != 0) ? 32'(m_conf) : 32'h0;
            chk("rnd.conflict_cnt", conflict_cnt, cnt_exp);
            cnt_exp = (PERF != 0) ? 32'(m_ovr) : 32'h0;
            chk("rnd.override_cnt", override_cnt, cnt_exp);
            @(posedge clk);
            #1;

            m_owner  = (winner == 1) ? 1 : ((winner == 2 && ex_wen == 4'h0) ? 2 : 0);
            m_starve = (if_req && winner != 1) ?
                       ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            m_conf  += (if_req && ex_req) ? 1 : 0;
            m_ovr   += ovr ? 1 : 0;
            if_pend  = if_req && (winner != 1);
            ex_pend  = ex_req && (winner != 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous SRAM port between the IF-stage instruction fetch and the EX-stage data access.
- Serves cores built on a single unified memory port instead of separate inst_sram/data_sram ports.
- Per cycle: grants the port to one requester, tracks the owner of the outstanding read, and routes returned data to that owner.
- Drives a stall request into the stall controller whenever a requester is refused.

Parameters:
- STARVE_MAX, 4: consecutive refused IF cycles before IF is forced to win one conflict. 0 = strict EX priority; IF is never forced.
- CNT_W, 32: width of the performance counters (used only under the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF fetch request, read only.
- if_addr  in  32  IF fetch address.
- if_gnt  out  1  IF owns the port this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  32  fetched instruction.
- ex_req  in  1  EX data request.
- ex_wen  in  4  byte write strobes; 0 = read.
- ex_addr  in  32  EX data address.
- ex_wdata  in  32  EX write data.
- ex_gnt  out  1  EX owns the port this cycle.
- ex_rvalid  out  1  ex_rdata valid this cycle.
- ex_rdata  out  32  load data.
- mem_en  out  1  shared SRAM enable.
- mem_wen  out  4  shared SRAM byte write enables.
- mem_addr  out  32  shared SRAM address.
- mem_wdata  out  32  shared SRAM write data.
- mem_rdata  in  32  shared SRAM read data, returned one cycle after the address.
- stallreq  out  1  pipeline stall request: a requester was refused this cycle.
- conflict_cnt  out  CNT_W  cycles with if_req && ex_req (optional feature).
- override_cnt  out  CNT_W  starvation overrides taken (optional feature).

Behaviour:
- Grant is combinational within the cycle. Exactly one grant or none; never both.
- Only ex_req: ex_gnt=1. Only if_req: if_gnt=1. Neither: both 0, mem_en=0.
- Both requesting: EX wins, unless STARVE_MAX!=0 and starve_cnt==STARVE_MAX, in which case IF wins (override).
- Granted requester's addr, wen and wdata drive the mem_* outputs; mem_en=1.
  - For IF: mem_wen=0 and mem_wdata=0.
  - When no grant: mem_* outputs all 0.
- starve_cnt (register, width clog2(STARVE_MAX+1)):
  - increments when if_req && !if_gnt, saturating at STARVE_MAX;
  - clears when if_gnt, or when if_req=0.
- owner register, states NONE / IF / EX, updated every edge:
  - next = IF if if_gnt;
  - next = EX if ex_gnt && ex_wen==0;
  - next = NONE otherwise, including all writes.
- Read data return, one cycle after grant:
  - owner==IF: if_rvalid=1 and if_rdata=mem_rdata.
  - owner==EX: ex_rvalid=1 and ex_rdata=mem_rdata.
  - Non-owner: rvalid=0 and rdata=0.
  - Each rvalid is high for exactly one cycle per granted read.
- Back-to-back grants are allowed every cycle (fully pipelined). A grant in cycle N+1 is independent of data returning in N+1.
- stallreq = (if_req && !if_gnt) || (ex_req && !ex_gnt). Combinational, no added latency.
- Requesters must hold req, addr, wen and wdata stable until granted. The arbiter does not latch refused requests.
- Reset (rst=0), asynchronous:
  - owner=NONE, starve_cnt=0, optional counters=0.
  - Consequently if_rvalid=ex_rvalid=0 and rdata=0.
  - A read granted in the cycle reset asserts produces no rvalid after reset releases.
- While in reset, grant and mem_* still follow the combinational rules. The integrating top gates requests low during reset.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - conflict_cnt increments on every cycle with if_req && ex_req.
  - override_cnt increments on every cycle where the starvation override grants IF.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both counter outputs are tied to 0, and no counter registers exist. All other behaviour is identical.

Test Plan:
1. IF-only read of 0xBFC00000, mem_rdata=0x24080001 the next cycle -> if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x24080001 in cycle 1; ex_rvalid=0; stallreq=0.
2. EX store, ex_wen=4'b0011, addr 0x80000010, wdata 0x1234ABCD -> mem_wen=0011 and mem_wdata=0x1234ABCD in the same cycle; no rvalid the next cycle.
3. Both requesting for 6 cycles, STARVE_MAX=4:
   - Cycles 0-3: EX granted, stallreq=1, starve_cnt reaches 4.
   - Cycle 4: IF granted (override), starve_cnt clears to 0.
   - Cycle 5: EX granted.
4. Alternating IF/EX reads on consecutive cycles -> each rvalid goes to the correct owner one cycle after its grant, data is never swapped, and the port is never idle.
5. IF read granted, then rst low mid-cycle before the next edge -> if_rvalid=0 immediately and after release; owner=NONE; counters 0.
6. With ARB_PERF_CNT_EN, 3 conflict cycles and 1 override -> conflict_cnt=3, override_cnt=1. Without the macro -> both read 0.
